// File: rtl/ahb_apb_bridge_nslv_pkg.sv
// Shared types for the AHB-Lite to APB bridge: transfer kinds, response codes, bridge FSM states.
package ahb_apb_bridge_nslv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } bridge_state_e;

  // NONSEQ and SEQ both carry htrans[1]; IDLE and BUSY never start an APB access.
  function automatic logic isActiveTrans(logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_nslv_if.sv
// AHB-Lite slave side and APB master side of the bridge bundled into one interface.
interface ahb_apb_bridge_nslv_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  import ahb_apb_bridge_nslv_pkg::*;

  logic               hselAPBif;
  logic [ADDR_W-1:0]  haddr;
  logic               hwrite;
  logic [1:0]         htrans;
  logic [2:0]         hsize;
  logic [2:0]         hburst;
  logic [DATA_W-1:0]  hwdata;
  logic               hreadyin;
  logic               hreadyout;
  logic [1:0]         hresp;
  logic [DATA_W-1:0]  hrdata;

  logic [ADDR_W-1:0]  paddr;
  logic               pwrite;
  logic [DATA_W-1:0]  pwdata;
  logic [NUM_SLV-1:0] pselx;
  logic               penable;
  logic [DATA_W-1:0]  prdata;
  logic               pready;
  logic               pslverr;

  // The bridge itself: an AHB slave that drives the APB bus.
  modport slave (
    input  hselAPBif, haddr, hwrite, htrans, hsize, hburst, hwdata, hreadyin,
    input  prdata, pready, pslverr,
    output hreadyout, hresp, hrdata,
    output paddr, pwrite, pwdata, pselx, penable
  );

  modport master (
    output hselAPBif, haddr, hwrite, htrans, hsize, hburst, hwdata, hreadyin,
    output prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata,
    input  paddr, pwrite, pwdata, pselx, penable
  );

endinterface

// File: rtl/ahb_apb_bridge_nslv_apb_addr_decoder.sv
// Maps an AHB address onto a one-hot APB slave select; slaves sit in equal power-of-two windows.
module apb_addr_decoder
  import ahb_apb_bridge_nslv_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                NUM_SLV       = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 12
) (
  input  logic [ADDR_W-1:0]  haddr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               hit_o
);

  logic [ADDR_W-1:0] slvIdx;

  // Addresses below the base wrap to a huge index, so the range check must be explicit.
  assign slvIdx = (haddr_i - SLV_BASE) >> SLV_SIZE_LOG2;
  assign hit_o  = (haddr_i >= SLV_BASE) && (slvIdx < ADDR_W'(NUM_SLV));

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = hit_o && (slvIdx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite slave to APB master bridge for NUM_SLV peripherals, one transfer in flight at a time.
// Optional APB_TIMEOUT_EN turns an ACCESS phase stuck on pready=0 into an AHB ERROR.
module ahb_apb_bridge_nslv
  import ahb_apb_bridge_nslv_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 12,
  parameter int                TIMEOUT_CYC   = 256
) (
  input logic                  clk,
  input logic                  hreset,
  ahb_apb_bridge_nslv_if.slave bus
);

  bridge_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [NUM_SLV-1:0] pselx_q, pselx_d;
  logic               penable_q, penable_d;
  logic               hreadyout_q, hreadyout_d;
  hresp_e             hresp_q, hresp_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic [2:0]         hsize_q, hsize_d;

  logic               valid;
  logic               decHit;
  logic [NUM_SLV-1:0] decSel;
  logic               timeout;

  apb_addr_decoder #(
    .ADDR_W       (ADDR_W),
    .NUM_SLV      (NUM_SLV),
    .SLV_BASE     (SLV_BASE),
    .SLV_SIZE_LOG2(SLV_SIZE_LOG2)
  ) u_dec (
    .haddr_i(bus.haddr),
    .sel_o  (decSel),
    .hit_o  (decHit)
  );

  assign valid = bus.hselAPBif & bus.hreadyin & isActiveTrans(bus.htrans);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;

  // Counts consecutive wait-state ACCESS cycles; any other cycle restarts it.
  assign tmoCnt_d = (state_q == ACCESS && !bus.pready) ? tmoCnt_q + 1'b1 : '0;
  assign timeout  = (state_q == ACCESS) && !bus.pready &&
                    (tmoCnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) tmoCnt_q <= '0;
    else        tmoCnt_q <= tmoCnt_d;
  end
`else
  localparam int unused_timeoutCyc = TIMEOUT_CYC;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (valid) state_d = decHit ? LATCH : ERR1;
      LATCH:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.pready)   state_d = bus.pslverr ? ERR1 : IDLE;
        else if (timeout) state_d = ERR1;
      end
      ERR1:   state_d = ERR2;
      ERR2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered, so each value is set up one state ahead of where it is seen.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    sel_d       = sel_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    hsize_d     = hsize_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          hreadyout_d = 1'b0;
          if (decHit) begin
            paddr_d  = bus.haddr;
            pwrite_d = bus.hwrite;
            sel_d    = decSel;
            hsize_d  = bus.hsize;
          end else begin
            hresp_d = ERROR;
          end
        end
      end
      LATCH: begin
        if (pwrite_q) pwdata_d = bus.hwdata;
        pselx_d = sel_q;
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (bus.pready || timeout) begin
          pselx_d   = '0;
          penable_d = 1'b0;
          if (bus.pready && !bus.pslverr) begin
            hreadyout_d = 1'b1;
            if (!pwrite_q) hrdata_d = bus.prdata;
          end else begin
            hresp_d = ERROR;
          end
        end
      end
      ERR1: hreadyout_d = 1'b1;
      ERR2: hresp_d = OKAY;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      sel_q       <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= OKAY;
      hrdata_q    <= '0;
      hsize_q     <= 3'b000;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      sel_q       <= sel_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      hsize_q     <= hsize_d;
    end
  end

  // hsize is kept for debug visibility only and hburst is ignored: each beat is a single transfer.
  logic unused_ok;
  assign unused_ok = ^{hsize_q, bus.hburst};

  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Directed bench for ahb_apb_bridge_nslv: scoreboard of expected AHB completions plus a small APB slave model.
module tb_ahb_apb_bridge_nslv;
  import ahb_apb_bridge_nslv_pkg::*;

  localparam int          TMO  = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  psel;
    logic        err;
    int          latency;
  } exp_t;

  logic clk = 1'b0;
  logic hreset;

  int          checks = 0;
  int          errors = 0;
  int          waitCfg;
  logic        errCfg;
  logic [31:0] dataCfg;
  int          accessCnt = 0;
  logic [31:0] modelRdata;
  logic [31:0] modelPwdata;
  exp_t        sbQ[$];

  ahb_apb_bridge_nslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  ahb_apb_bridge_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_BASE(BASE),
    .SLV_SIZE_LOG2(12), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk   (clk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-slave system: the bridge's own ready is the bus ready.
  assign bus.hreadyin = bus.hreadyout;

  // APB slave: waitCfg wait states per access, then pready with the configured error/data.
  always @(posedge clk) accessCnt <= bus.penable ? accessCnt + 1 : 0;
  assign bus.pready  = (accessCnt >= waitCfg);
  assign bus.pslverr = errCfg;
  assign bus.prdata  = dataCfg;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives an address phase in the current cycle and records what the bridge should answer.
  task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                               input int waits, input logic perr, input logic [31:0] pdata);
    exp_t        e;
    logic [31:0] off;
    logic        hit;
    bit          tmoHit;
    off    = addr - BASE;
    hit    = (addr >= BASE) && ((off >> 12) < 32'd4);
    tmoHit = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmoHit = (waits >= TMO);
`endif
    e.addr  = addr;
    e.write = write;
    e.wdata = wdata;
    e.rdata = pdata;
    e.psel  = hit ? (4'b0001 << off[13:12]) : 4'b0000;
    e.err   = !hit || perr || tmoHit;
    if (!hit)        e.latency = 2;
    else if (tmoHit) e.latency = 4 + TMO;
    else if (perr)   e.latency = 5 + waits;
    else             e.latency = 4 + waits;
    sbQ.push_back(e);
    bus.hselAPBif = 1'b1;
    bus.haddr     = addr;
    bus.hwrite    = write;
    bus.htrans    = HTRANS_NONSEQ;
    bus.hsize     = 3'b010;
    waitCfg       = waits;
    errCfg        = perr;
    dataCfg       = pdata;
  endtask

  task automatic collectResponse();
    exp_t        e;
    int          cyc;
    bit          done;
    bit          gotAccess;
    logic [3:0]  pselSeen;
    logic [31:0] obsPaddr;
    logic [31:0] obsPwdata;
    logic [1:0]  prevHresp;
    e         = sbQ.pop_front();
    cyc       = 0;
    done      = 1'b0;
    gotAccess = 1'b0;
    pselSeen  = 4'b0000;
    obsPaddr  = '0;
    obsPwdata = '0;
    prevHresp = 2'b11;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.htrans    = HTRANS_IDLE;
        bus.hselAPBif = 1'b0;
        bus.hwdata    = e.wdata;
        checkOutput("accepted_hreadyout", bus.hreadyout, 1'b0);
      end
      pselSeen |= bus.pselx;
      if (bus.penable && !gotAccess) begin
        gotAccess = 1'b1;
        obsPaddr  = bus.paddr;
        obsPwdata = bus.pwdata;
      end
      if (bus.hreadyout) done = 1'b1;
      else               prevHresp = bus.hresp;
    end
    checkOutput("completed", done, 1'b1);
    checkOutput("latency", cyc, e.latency);
    checkOutput("pselx", pselSeen, e.psel);
    if (e.err) begin
      checkOutput("hresp_err_first", prevHresp, ERROR);
      checkOutput("hresp_err_second", bus.hresp, ERROR);
    end else begin
      checkOutput("hresp_okay", bus.hresp, OKAY);
    end
    if (!e.err && !e.write) modelRdata = e.rdata;
    checkOutput("hrdata", bus.hrdata, modelRdata);
    if (e.psel != 4'b0000) begin
      if (e.write) modelPwdata = e.wdata;
      checkOutput("access_seen", gotAccess, 1'b1);
      checkOutput("paddr", obsPaddr, e.addr);
      checkOutput("pwdata", obsPwdata, modelPwdata);
    end else begin
      checkOutput("no_access", gotAccess, 1'b0);
    end
  endtask

  initial begin
    hreset        = 1'b1;
    bus.hselAPBif = 1'b0;
    bus.haddr     = '0;
    bus.hwrite    = 1'b0;
    bus.htrans    = HTRANS_IDLE;
    bus.hsize     = 3'b010;
    bus.hburst    = 3'b000;
    bus.hwdata    = '0;
    waitCfg       = 0;
    errCfg        = 1'b0;
    dataCfg       = '0;
    modelRdata    = '0;
    modelPwdata   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hreadyout", bus.hreadyout, 1'b1);
    checkOutput("rst_hresp", bus.hresp, OKAY);
    checkOutput("rst_hrdata", bus.hrdata, 32'h0);
    checkOutput("rst_paddr", bus.paddr, 32'h0);
    checkOutput("rst_pwrite", bus.pwrite, 1'b0);
    checkOutput("rst_pwdata", bus.pwdata, 32'h0);
    checkOutput("rst_pselx", bus.pselx, 4'b0000);
    checkOutput("rst_penable", bus.penable, 1'b0);
    hreset = 1'b0;
    tick();

    $display("[TB] zero-wait write to slave 1");
    applyStimulus(32'h8000_1004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    collectResponse();

    $display("[TB] read from slave 3 with three wait states");
    applyStimulus(32'h8000_3000, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
    collectResponse();

    $display("[TB] write outside every slave window");
    applyStimulus(32'h7000_0000, 1'b1, 32'hFFFF_0000, 0, 1'b0, 32'h0);
    collectResponse();
    tick();
    checkOutput("miss_hresp_back_okay", bus.hresp, OKAY);

    $display("[TB] read from slave 0 answered with pslverr");
    applyStimulus(32'h8000_0000, 1'b0, 32'h0, 0, 1'b1, 32'hDEAD_0000);
    collectResponse();
    tick();
    checkOutput("slverr_hresp_back_okay", bus.hresp, OKAY);

    $display("[TB] back-to-back writes to slaves 0 and 2");
    applyStimulus(32'h8000_0010, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0);
    collectResponse();
    applyStimulus(32'h8000_2020, 1'b1, 32'h3333_4444, 1, 1'b0, 32'h0);
    collectResponse();

    $display("[TB] BUSY transfers get a zero-wait OKAY");
    bus.hselAPBif = 1'b1;
    bus.htrans    = HTRANS_BUSY;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("busy_hreadyout", bus.hreadyout, 1'b1);
      checkOutput("busy_hresp", bus.hresp, OKAY);
      checkOutput("busy_pselx", bus.pselx, 4'b0000);
    end
    bus.htrans    = HTRANS_IDLE;
    bus.hselAPBif = 1'b0;
    tick();

`ifdef APB_TIMEOUT_EN
    $display("[TB] pready stuck low until the access timeout");
    applyStimulus(32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 1000, 1'b0, 32'h0);
    collectResponse();
    tick();
    checkOutput("tmo_hresp_back_okay", bus.hresp, OKAY);
`endif

    $display("[TB] reset asserted during ACCESS");
    bus.hselAPBif = 1'b1;
    bus.haddr     = 32'h8000_0000;
    bus.hwrite    = 1'b0;
    bus.htrans    = HTRANS_NONSEQ;
    waitCfg       = 20;
    errCfg        = 1'b0;
    tick();
    bus.htrans    = HTRANS_IDLE;
    bus.hselAPBif = 1'b0;
    for (int i = 0; i < 10 && !bus.penable; i++) tick();
    checkOutput("rst_mid_access_reached", bus.penable, 1'b1);
    #2;
    hreset = 1'b1;
    #1;
    checkOutput("rst_mid_pselx", bus.pselx, 4'b0000);
    checkOutput("rst_mid_penable", bus.penable, 1'b0);
    checkOutput("rst_mid_hresp", bus.hresp, OKAY);
    checkOutput("rst_mid_hreadyout", bus.hreadyout, 1'b1);
    checkOutput("rst_mid_hrdata", bus.hrdata, 32'h0);
    tick();
    hreset  = 1'b0;
    waitCfg = 0;
    tick();
    checkOutput("post_rst_hreadyout", bus.hreadyout, 1'b1);
    checkOutput("post_rst_pselx", bus.pselx, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
